// File: rtl/hazard_stall_ctrl_pkg.sv
// Purpose : shared opcode constants, FSM state type and rs2-usage decode for hazard_stall_ctrl.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_stall_ctrl_pkg;

  // Opcodes, kept bit-identical to the ID control unit decode.
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BEQ_OP = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_MEM_WAIT,
    ST_TIMEOUT
  } state_e;

  // Only instructions that actually read rs2 can hit a load-use on rs2;
  // I-type and lw carry immediate bits in the rs2 field.
  function automatic logic uses_rs2(input logic [6:0] op);
    logic r;
    case (op)
      R_TYPE, SW_OP, BEQ_OP: r = 1'b1;
      I_TYPE, LW_OP:         r = 1'b0;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Purpose : W-bit event counter that sticks at all-ones instead of wrapping.
// Latency : count visible one cycle after inc_i.
// Backpressure: none; inc_i is sampled every cycle.
// Ports: clk_i clock, rst_i async active-low clear, inc_i count enable, cnt_o count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Purpose : load-use / taken-branch hazard control and memory-wait freeze for the 5-stage core.
// Latency : control outputs are combinational (Mealy) on the ID/EX inputs; Err_o and counters registered.
// Backpressure: MemReq_i without MemAck_i freezes the whole pipeline until ack or timeout.
// Ports: clk_i/rst_i clock and async active-low reset; start_i leaves IDLE; IFID_*/IDEX_* hazard
//        fields; Branch_i/RegEq_i branch resolve; MemReq_i/MemAck_i data-memory handshake;
//        NoOP_o/PCWrite_o/IFIDWrite_o/Flush_o/AllStall_o pipeline control; Err_o sticky
//        timeout; StallCnt_o/FlushCnt_o saturating statistics.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       IFID_Op_i,
  input  logic [4:0]       IFID_RS1_i,
  input  logic [4:0]       IFID_RS2_i,
  input  logic [4:0]       IDEX_RD_i,
  input  logic             IDEX_MemRead_i,
  input  logic             Branch_i,
  input  logic             RegEq_i,
  input  logic             MemReq_i,
  input  logic             MemAck_i,
  output logic             NoOP_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             Flush_o,
  output logic             AllStall_o,
  output logic             Err_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            err_q;
  logic            loaduse, taken, memhold;
  logic            stall_inc;

  assign loaduse = IDEX_MemRead_i & (IDEX_RD_i != 5'd0) &
                   ((IDEX_RD_i == IFID_RS1_i) |
                    (uses_rs2(IFID_Op_i) & (IDEX_RD_i == IFID_RS2_i)));
  assign taken   = Branch_i & RegEq_i;
  assign memhold = MemReq_i & ~MemAck_i;

  // Data inputs only reach outputs/counters from RUN or MEM_WAIT, so junk on
  // them while IDLE or TIMEOUT cannot leak out.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    NoOP_o      = 1'b0;
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    Flush_o     = 1'b0;
    AllStall_o  = 1'b0;
    stall_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        NoOP_o = 1'b1;
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if ((state_q == ST_MEM_WAIT) && !MemAck_i) begin
          AllStall_o = 1'b1;
          if (wcnt_q == WC_W'(MEM_TIMEOUT)) begin
            state_d = ST_TIMEOUT;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else if ((state_q == ST_RUN) && memhold) begin
          AllStall_o = 1'b1;
          state_d    = ST_MEM_WAIT;
          wcnt_d     = WC_W'(1);
        end else begin
          // Plain RUN cycle, or the ack cycle of MEM_WAIT: the ack wins over
          // timeout even when the counter has reached its limit.
          state_d = ST_RUN;
          wcnt_d  = '0;
          if (loaduse) begin
            // A taken branch here is deferred: it is re-seen after the bubble.
            NoOP_o    = 1'b1;
            stall_inc = 1'b1;
          end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
            Flush_o     = taken;
          end
        end
      end
      ST_TIMEOUT: begin
        NoOP_o     = 1'b1;
        AllStall_o = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_d == ST_TIMEOUT) err_q <= 1'b1;
    end
  end

  assign Err_o = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (StallCnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (Flush_o),
    .cnt_o (FlushCnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose : self-checking bench for hazard_stall_ctrl (default build and CNT_W=3/MEM_TIMEOUT=4 build).
// Latency : checks Mealy outputs each cycle just after the falling edge.
// Backpressure: n/a.
module tb_hazard_stall_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [6:0] IFID_Op_i;
  logic [4:0] IFID_RS1_i, IFID_RS2_i, IDEX_RD_i;
  logic       IDEX_MemRead_i, Branch_i, RegEq_i, MemReq_i, MemAck_i;

  logic        a_noop, a_pcw, a_ifidw, a_flush, a_alls, a_err;
  logic [15:0] a_stall, a_fcnt;
  logic        b_noop, b_pcw, b_ifidw, b_flush, b_alls, b_err;
  logic [2:0]  b_stall, b_fcnt;

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .IFID_Op_i(IFID_Op_i), .IFID_RS1_i(IFID_RS1_i), .IFID_RS2_i(IFID_RS2_i),
    .IDEX_RD_i(IDEX_RD_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .Branch_i(Branch_i), .RegEq_i(RegEq_i), .MemReq_i(MemReq_i), .MemAck_i(MemAck_i),
    .NoOP_o(a_noop), .PCWrite_o(a_pcw), .IFIDWrite_o(a_ifidw), .Flush_o(a_flush),
    .AllStall_o(a_alls), .Err_o(a_err), .StallCnt_o(a_stall), .FlushCnt_o(a_fcnt)
  );

  hazard_stall_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .IFID_Op_i(IFID_Op_i), .IFID_RS1_i(IFID_RS1_i), .IFID_RS2_i(IFID_RS2_i),
    .IDEX_RD_i(IDEX_RD_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .Branch_i(Branch_i), .RegEq_i(RegEq_i), .MemReq_i(MemReq_i), .MemAck_i(MemAck_i),
    .NoOP_o(b_noop), .PCWrite_o(b_pcw), .IFIDWrite_o(b_ifidw), .Flush_o(b_flush),
    .AllStall_o(b_alls), .Err_o(b_err), .StallCnt_o(b_stall), .FlushCnt_o(b_fcnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 running, 2 waiting on memory, 3 timed out.
  int m_mode[2], m_wait[2], m_sc[2], m_fc[2];
  bit m_err[2];
  int n_mode[2], n_wait[2];
  bit sinc[2], finc[2];
  int e_ctl[2];   // {noop,pcw,ifidw,flush,allstall,err}

  function automatic int lim_wait(int d); return (d == 0) ? 64 : 4; endfunction
  function automatic int cap(int d);      return (d == 0) ? 65535 : 7; endfunction

  task automatic model_reset(int d);
    m_mode[d] = 0; m_wait[d] = 0; m_sc[d] = 0; m_fc[d] = 0; m_err[d] = 0;
  endtask

  task automatic model_comb(int d);
    bit rs2_read, lu, tk, hold;
    rs2_read = (IFID_Op_i == 7'b0110011) || (IFID_Op_i == 7'b0100011) || (IFID_Op_i == 7'b1100011);
    lu   = IDEX_MemRead_i && (IDEX_RD_i != 0) &&
           ((IDEX_RD_i == IFID_RS1_i) || (rs2_read && (IDEX_RD_i == IFID_RS2_i)));
    tk   = Branch_i && RegEq_i;
    hold = MemReq_i && !MemAck_i;
    n_mode[d] = m_mode[d]; n_wait[d] = m_wait[d]; sinc[d] = 0; finc[d] = 0;
    if (m_mode[d] == 0) begin
      e_ctl[d] = 'b100000;
      if (start_i) n_mode[d] = 1;
    end else if (m_mode[d] == 3) begin
      e_ctl[d] = 'b100011;
    end else if (m_mode[d] == 2 && !MemAck_i) begin
      e_ctl[d] = 'b000010;
      if (m_wait[d] == lim_wait(d)) n_mode[d] = 3;
      else n_wait[d] = m_wait[d] + 1;
    end else if (m_mode[d] == 1 && hold) begin
      e_ctl[d] = 'b000010; n_mode[d] = 2; n_wait[d] = 1;
    end else begin
      n_mode[d] = 1; n_wait[d] = 0;
      if (lu)      begin e_ctl[d] = 'b100000; sinc[d] = 1; end
      else if (tk) begin e_ctl[d] = 'b011100; finc[d] = 1; end
      else               e_ctl[d] = 'b011000;
    end
    e_ctl[d] = e_ctl[d] | int'(m_err[d]);
  endtask

  task automatic model_commit(int d);
    m_mode[d] = n_mode[d];
    m_wait[d] = n_wait[d];
    if (n_mode[d] == 3) m_err[d] = 1;
    if (sinc[d] && m_sc[d] < cap(d)) m_sc[d]++;
    if (finc[d] && m_fc[d] < cap(d)) m_fc[d]++;
  endtask

  function automatic int act_ctl(int d);
    return (d == 0) ? int'({a_noop, a_pcw, a_ifidw, a_flush, a_alls, a_err})
                    : int'({b_noop, b_pcw, b_ifidw, b_flush, b_alls, b_err});
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string nm);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_i) model_reset(d);
      model_comb(d);
      chk($sformatf("%s[%0d].ctl", nm, d), act_ctl(d), e_ctl[d]);
      chk($sformatf("%s[%0d].stallcnt", nm, d), (d == 0) ? int'(a_stall) : int'(b_stall), m_sc[d]);
      chk($sformatf("%s[%0d].flushcnt", nm, d), (d == 0) ? int'(a_fcnt) : int'(b_fcnt), m_fc[d]);
    end
    @(posedge clk_i);
    for (int d = 0; d < 2; d++) if (rst_i) model_commit(d);
    @(negedge clk_i);
  endtask

  task automatic clear_in();
    start_i = 0; IFID_Op_i = 7'b0110011; IFID_RS1_i = 0; IFID_RS2_i = 0; IDEX_RD_i = 0;
    IDEX_MemRead_i = 0; Branch_i = 0; RegEq_i = 0; MemReq_i = 0; MemAck_i = 0;
  endtask

  task automatic rand_data();
    IFID_Op_i = 7'($urandom); IFID_RS1_i = 5'($urandom); IFID_RS2_i = 5'($urandom);
    IDEX_RD_i = 5'($urandom); IDEX_MemRead_i = 1'($urandom); Branch_i = 1'($urandom);
    RegEq_i = 1'($urandom); MemReq_i = 1'($urandom); MemAck_i = 1'($urandom);
  endtask

  task automatic restart();
    clear_in(); rst_i = 0; step("rst");
    rst_i = 1; start_i = 1; step("start");
    start_i = 0;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, eq;
    logic [3:0] exp;   // {noop,pcw,ifidw,flush}
  } vec_t;

  vec_t vt[12];
  logic [6:0] ops[5];

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    vt[0]  = '{7'b0110011, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1000}; // add after lw, rs1 hit
    vt[1]  = '{7'b0110011, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1000}; // R-type rs2 hit
    vt[2]  = '{7'b0010011, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0110}; // I-type rs2 field ignored
    vt[3]  = '{7'b0000011, 5'd2, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0110}; // lw rs2 field ignored
    vt[4]  = '{7'b0100011, 5'd2, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1000}; // sw rs2 hit
    vt[5]  = '{7'b1100011, 5'd2, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1000}; // beq rs2 hit
    vt[6]  = '{7'b0110011, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0110}; // x0 never hazards
    vt[7]  = '{7'b0110011, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0110}; // not a load
    vt[8]  = '{7'b1100011, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 4'b0111}; // taken, no hazard
    vt[9]  = '{7'b1100011, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 4'b1000}; // taken deferred by load-use
    vt[10] = '{7'b1100011, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 4'b0110}; // not taken
    vt[11] = '{7'b0110011, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 4'b0110}; // RegEq without branch

    // Reset with junk on data inputs: IDLE outputs must be clean.
    rst_i = 0; rand_data(); start_i = 0;
    @(negedge clk_i);
    #1;
    chk("reset_noop", int'(a_noop), 1);
    chk("reset_pcw", int'(a_pcw), 0);
    step("reset");
    rst_i = 1;
    for (int i = 0; i < 3; i++) begin rand_data(); start_i = 0; step("idle"); end
    rand_data(); start_i = 1; step("start");
    clear_in();
    #1;
    chk("run_pcw", int'(a_pcw), 1);
    chk("run_ifidw", int'(a_ifidw), 1);
    chk("run_noop", int'(a_noop), 0);
    step("run0");

    // Single-cycle hazard table, applied from RUN.
    for (int i = 0; i < 12; i++) begin
      clear_in();
      IFID_Op_i = vt[i].op; IFID_RS1_i = vt[i].rs1; IFID_RS2_i = vt[i].rs2; IDEX_RD_i = vt[i].rd;
      IDEX_MemRead_i = vt[i].mr; Branch_i = vt[i].br; RegEq_i = vt[i].eq;
      #1;
      chk($sformatf("vec%0d", i), int'({a_noop, a_pcw, a_ifidw, a_flush}), int'(vt[i].exp));
      step($sformatf("vec%0d", i));
    end

    // 10 back-to-back load-use stalls: 3-bit counter must stop at 7.
    clear_in();
    IFID_RS1_i = 5'd5; IDEX_RD_i = 5'd5; IDEX_MemRead_i = 1;
    for (int i = 0; i < 10; i++) step("sat");
    chk("sat_at_7", int'(b_stall), 7);

    // 5 un-acked memory cycles then ack. Small build times out after 4 wait cycles.
    clear_in(); MemReq_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("memwait_allstall", int'(a_alls), 1);
      step("memwait");
    end
    MemAck_i = 1;
    #1;
    chk("ack_allstall", int'(a_alls), 0);
    chk("timeout_err", int'(b_err), 1);
    step("ack");
    clear_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("after_ack_pcw", int'(a_pcw), 1);
      chk("err_sticky", int'(b_err), 1);
      step("post_ack");
    end

    // Async reset in TIMEOUT takes effect without a clock edge.
    rst_i = 0;
    #1;
    chk("rst_err_clear", int'(b_err), 0);
    chk("rst_idle_noop", int'(b_noop), 1);
    step("rst_to");
    rst_i = 1; start_i = 1; step("restart");
    clear_in();

    // Ack on the last allowed wait cycle beats the timeout; taken branch evaluated then.
    MemReq_i = 1;
    for (int i = 0; i < 4; i++) step("late_wait");
    MemAck_i = 1; Branch_i = 1; RegEq_i = 1;
    #1;
    chk("late_ack_flush", int'(b_flush), 1);
    chk("late_ack_alls", int'(b_alls), 0);
    step("late_ack");
    clear_in();
    #1;
    chk("late_ack_run", int'(b_pcw), 1);
    chk("late_ack_noerr", int'(b_err), 0);
    step("late_run");

    // Constrained-random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_i = ($urandom_range(0, 59) != 0);
      start_i = ($urandom_range(0, 3) == 0);
      IFID_Op_i = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
      IFID_RS1_i = 5'($urandom_range(0, 3));
      IFID_RS2_i = 5'($urandom_range(0, 3));
      IDEX_RD_i = 5'($urandom_range(0, 3));
      IDEX_MemRead_i = 1'($urandom);
      Branch_i = 1'($urandom);
      RegEq_i = 1'($urandom);
      MemReq_i = ($urandom_range(0, 7) == 0);
      MemAck_i = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    restart();
    step("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
